// File: rtl/sindoku_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sindoku_btn_conditioner
// Function : Pushbutton synchronizer/debouncer with single-press enable and
//            optional auto-repeat (enabled by macro SINDOKU_BTN_AUTOREPEAT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sindoku_btn_conditioner #(
  parameter int DB_CYC   = 1000000,
  parameter int RPT_DLY  = 50000000,
  parameter int RPT_RATE = 10000000
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic PB,
  output logic DPB,
  output logic SCEN,
  output logic MCEN
);

  // Counter is at least 28 bits and grows if a parameter would not fit.
  localparam int c_MAX_CNT = (DB_CYC > RPT_DLY) ?
                             ((DB_CYC > RPT_RATE) ? DB_CYC : RPT_RATE) :
                             ((RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE);
  localparam int c_CNT_W   = ($clog2(c_MAX_CNT + 1) > 28) ? $clog2(c_MAX_CNT + 1) : 28;

  localparam logic [c_CNT_W-1:0] c_ZERO    = '0;
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_DB_LAST = c_CNT_W'(DB_CYC - 2);
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
  localparam logic [c_CNT_W-1:0] c_DLY_LAST  = c_CNT_W'(RPT_DLY - 1);
  localparam logic [c_CNT_W-1:0] c_RATE_LAST = c_CNT_W'(RPT_RATE - 1);
`endif

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    QUAL_PRESS   = 3'd1,
    PRESS_PULSE  = 3'd2,
    HOLD         = 3'd3,
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
    RPT_PULSE    = 3'd4,
    RPT_WAIT     = 3'd5,
`endif
    QUAL_RELEASE = 3'd6
  } state_t;

  logic               r_sync_meta;
  logic               r_pb_s;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_dpb;
  logic               r_scen;
  logic               r_mcen;
  logic               w_dpb_nxt;
  logic               w_scen_nxt;
  logic               w_mcen_nxt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync_meta <= 1'b0;
      r_pb_s      <= 1'b0;
    end else begin
      r_sync_meta <= PB;
      r_pb_s      <= r_sync_meta;
    end
  end

  // In HOLD/RPT_WAIT the counter holds cycles elapsed since the last
  // repeat reference cycle; in the qualify states it counts samples seen.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (r_pb_s) begin
          w_state_nxt = QUAL_PRESS;
          w_cnt_nxt   = c_ZERO;
        end
      end
      QUAL_PRESS: begin
        if (!r_pb_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = c_ZERO;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = PRESS_PULSE;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      PRESS_PULSE: begin
        w_state_nxt = HOLD;
        w_cnt_nxt   = c_ONE;
      end
      HOLD: begin
        if (!r_pb_s) begin
          w_state_nxt = QUAL_RELEASE;
          w_cnt_nxt   = c_ZERO;
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
        end else if (r_cnt == c_DLY_LAST) begin
          w_state_nxt = RPT_PULSE;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
`endif
        end
      end
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
      RPT_PULSE: begin
        w_state_nxt = RPT_WAIT;
        w_cnt_nxt   = c_ONE;
      end
      RPT_WAIT: begin
        if (!r_pb_s) begin
          w_state_nxt = QUAL_RELEASE;
          w_cnt_nxt   = c_ZERO;
        end else if (r_cnt == c_RATE_LAST) begin
          w_state_nxt = RPT_PULSE;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
`endif
      QUAL_RELEASE: begin
        if (r_pb_s) begin
          // Bounce back: HOLD's first cycle becomes the new repeat reference.
          w_state_nxt = HOLD;
          w_cnt_nxt   = c_ZERO;
        end else if (r_cnt == c_DB_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = c_ZERO;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = c_ZERO;
      end
    endcase
  end

  // Outputs are registered copies of the next-state decode, so each one is
  // a plain flop tracking the state register with no decode glitches.
  always_comb begin
    w_dpb_nxt  = (w_state_nxt != IDLE) && (w_state_nxt != QUAL_PRESS);
    w_scen_nxt = (w_state_nxt == PRESS_PULSE);
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
    w_mcen_nxt = (w_state_nxt == PRESS_PULSE) || (w_state_nxt == RPT_PULSE);
`else
    w_mcen_nxt = (w_state_nxt == PRESS_PULSE);
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= c_ZERO;
      r_dpb   <= 1'b0;
      r_scen  <= 1'b0;
      r_mcen  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dpb   <= w_dpb_nxt;
      r_scen  <= w_scen_nxt;
      r_mcen  <= w_mcen_nxt;
    end
  end

  assign DPB  = r_dpb;
  assign SCEN = r_scen;
  assign MCEN = r_mcen;

endmodule
`default_nettype wire

// File: tb/tb_sindoku_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sindoku_btn_conditioner
// Function : Directed and random stimulus for sindoku_btn_conditioner,
//            checked against a behavioural press/release/repeat model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sindoku_btn_conditioner;

  localparam int DB_CYC   = 4;
  localparam int RPT_DLY  = 10;
  localparam int RPT_RATE = 5;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  logic PB      = 1'b0;
  logic DPB;
  logic SCEN;
  logic MCEN;

  int vectors     = 0;
  int miscompares = 0;

  sindoku_btn_conditioner #(
    .DB_CYC   (DB_CYC),
    .RPT_DLY  (RPT_DLY),
    .RPT_RATE (RPT_RATE)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .PB      (PB),
    .DPB     (DPB),
    .SCEN    (SCEN),
    .MCEN    (MCEN)
  );

  always #5 Clk = ~Clk;

  // Reference model: button seen through a two-sample delay; a press is
  // DB_CYC equal samples, repeats fire at fixed ages after a reference cycle.
  logic m_p0, m_p1;
  logic m_pressed, m_skip;
  int   m_hi_run, m_lo_run, m_age, m_period;
  logic e_dpb, e_scen, e_mcen;

  function automatic void model_reset();
    m_p0 = 1'b0; m_p1 = 1'b0;
    m_pressed = 1'b0; m_skip = 1'b0;
    m_hi_run = 0; m_lo_run = 0; m_age = 0; m_period = RPT_DLY;
    e_dpb = 1'b0; e_scen = 1'b0; e_mcen = 1'b0;
  endfunction

  function automatic void model_edge(input logic pb_now);
    logic s;
    s = m_p1; m_p1 = m_p0; m_p0 = pb_now;
    e_scen = 1'b0; e_mcen = 1'b0;
    if (!m_pressed) begin
      m_hi_run = s ? m_hi_run + 1 : 0;
      if (m_hi_run == DB_CYC) begin
        m_pressed = 1'b1; m_skip = 1'b1;
        m_hi_run = 0; m_lo_run = 0; m_age = 0; m_period = RPT_DLY;
        e_scen = 1'b1; e_mcen = 1'b1;
      end
    end else if (m_skip) begin
      m_skip = 1'b0;
      m_age++;
    end else if (m_lo_run > 0) begin
      if (!s) begin
        m_lo_run++;
        if (m_lo_run == DB_CYC) begin
          m_pressed = 1'b0; m_lo_run = 0;
        end
      end else begin
        m_lo_run = 0; m_age = 0; m_period = RPT_DLY;
      end
    end else if (!s) begin
      m_lo_run = 1;
    end else begin
      m_age++;
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
      if (m_age == m_period) begin
        e_mcen = 1'b1; m_skip = 1'b1; m_age = 0; m_period = RPT_RATE;
      end
`endif
    end
    e_dpb = m_pressed;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed {DPB,SCEN,MCEN}=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else          model_edge(PB);
    @(negedge Clk);
    check(tag, {DPB, SCEN, MCEN}, {e_dpb, e_scen, e_mcen});
  endtask

  task automatic async_reset();
    #2 Reset_n = 1'b0;
    #1 check("async_reset", {DPB, SCEN, MCEN}, 3'b000);
    model_reset();
    step("reset_low");
    Reset_n = 1'b1;
  endtask

  task automatic idle(input int n);
    PB = 1'b0;
    for (int i = 0; i < n; i++) step("idle");
  endtask

  logic [2:0] want;
  logic       ar;
  int         n_scen, n_mcen, seg_len;

  initial begin
`ifdef SINDOKU_BTN_AUTOREPEAT_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    model_reset();
    for (int i = 0; i < 3; i++) step("reset_state");
    Reset_n = 1'b1;
    idle(4);

    // Short glitch: three high samples never qualify.
    PB = 1'b1;
    for (int e = 0; e < 3; e++) step("glitch");
    PB = 1'b0;
    for (int e = 3; e < 13; e++) begin
      step("glitch_model");
      check("glitch_quiet", {DPB, SCEN, MCEN}, 3'b000);
    end

    // Long hold, release before edge 40.
    PB = 1'b1;
    for (int e = 0; e < 50; e++) begin
      if (e == 40) PB = 1'b0;
      step("hold_model");
      want = {(e >= 5) && (e < 45), e == 5,
              (e == 5) || (ar && e >= 15 && e <= 40 && (e - 15) % 5 == 0)};
      check($sformatf("hold_e%0d", e), {DPB, SCEN, MCEN}, want);
    end
    idle(4);

    // Release bounce during HOLD.
    PB = 1'b1;
    for (int e = 0; e < 31; e++) begin
      if (e == 8)  PB = 1'b0;
      if (e == 10) PB = 1'b1;
      step("bounce_model");
      want = {e >= 5, e == 5, (e == 5) || (ar && (e == 22 || e == 27))};
      check($sformatf("bounce_e%0d", e), {DPB, SCEN, MCEN}, want);
    end
    idle(12);

    // Reset during RPT_WAIT with button still held, then re-qualification.
    PB = 1'b1;
    for (int e = 0; e < 18; e++) step("pre_reset");
    async_reset();
    for (int e = 0; e < 11; e++) begin
      step("post_reset_model");
      want = {e >= 5, e == 5, e == 5};
      check($sformatf("post_reset_e%0d", e), {DPB, SCEN, MCEN}, want);
    end
    idle(12);

    // Fifty-cycle hold: count enables.
    n_scen = 0; n_mcen = 0;
    PB = 1'b1;
    for (int e = 0; e < 50; e++) begin
      step("hold50");
      n_scen += int'(SCEN);
      n_mcen += int'(MCEN);
    end
    check("hold50_scen_count", 3'(n_scen), 3'd1);
    check("hold50_mcen_count", 3'(n_mcen), ar ? 3'd8 : 3'd1);
    idle(12);

    // Random bouncing button with occasional asynchronous resets.
    for (int seg = 0; seg < 80; seg++) begin
      PB = 1'($urandom_range(0, 1));
      seg_len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 35);
      for (int i = 0; i < seg_len; i++) step("random");
      if ($urandom_range(0, 19) == 0) async_reset();
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sindoku_btn_conditioner.md
SINDOKU_BTN_CONDITIONER -- requirements
Module: sindoku_btn_conditioner

Interface
REQ-001 SHALL have parameter DB_CYC, default 1000000, the number of consecutive stable synchronized samples that qualifies a press or a release (10 ms at 100 MHz).
REQ-002 SHALL have parameter RPT_DLY, default 50000000, the cycles from the SCEN pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter RPT_RATE, default 10000000, the cycles between successive auto-repeat pulses.
REQ-004 SHALL have port Clk, input, 1 bit: the single system clock (100 MHz); all logic is on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port PB, input, 1 bit: raw, asynchronous, bouncing pushbutton level, active-high.
REQ-007 SHALL have port DPB, output, 1 bit: debounced button level.
REQ-008 SHALL have port SCEN, output, 1 bit: single-cycle pulse, once per qualified press.
REQ-009 SHALL have port MCEN, output, 1 bit: single-cycle pulse on a qualified press and on each auto-repeat; it drives cursor-move inputs of the sindoku FSM.

Function
REQ-010 SHALL pass PB through a 2-flop synchronizer; only the synchronized value (pb_s) is used downstream.
REQ-011 SHALL implement states IDLE, QUAL_PRESS, PRESS_PULSE, HOLD, RPT_PULSE, RPT_WAIT, QUAL_RELEASE, plus one shared counter of at least 28 bits.
REQ-012 SHALL move from IDLE to QUAL_PRESS on pb_s=1, with the counter cleared.
REQ-013 SHALL return from QUAL_PRESS to IDLE on any pb_s=0 sample, with no output activity; glitches shorter than DB_CYC samples are ignored.
REQ-014 SHALL, after DB_CYC consecutive pb_s=1 samples, assert SCEN=1 and MCEN=1 for exactly one cycle (PRESS_PULSE) in the cycle immediately following the DB_CYC-th sample, then enter HOLD.
REQ-015 SHALL assert the first auto-repeat MCEN pulse (RPT_PULSE) exactly RPT_DLY cycles after the SCEN cycle, and further pulses every RPT_RATE cycles while pb_s stays 1; SCEN is never asserted on a repeat.
REQ-016 SHALL enter QUAL_RELEASE on pb_s=0 in HOLD or RPT_WAIT; no MCEN pulses occur in QUAL_RELEASE.
REQ-017 SHALL, in QUAL_RELEASE, go to IDLE after DB_CYC consecutive pb_s=0 samples, with DPB falling in the cycle after the DB_CYC-th sample.
REQ-018 SHALL, on pb_s=1 in QUAL_RELEASE, return to HOLD with the repeat-delay timer restarted; no SCEN is generated.
REQ-019 SHALL hold DPB=1 from the PRESS_PULSE cycle through the end of QUAL_RELEASE, and 0 otherwise.
REQ-020 SHALL decode SCEN, MCEN and DPB from the state register only (Moore); they are glitch-free and never high for two consecutive cycles (SCEN/MCEN).
REQ-021 SHALL require DB_CYC ≥ 2, RPT_DLY ≥ 3 and RPT_RATE ≥ 2; the counter never wraps in any state.

Reset
REQ-022 SHALL, while Reset_n=0, force state IDLE, clear the counter and the synchronizer flops, and drive DPB=0, SCEN=0, MCEN=0 immediately (asynchronously).
REQ-023 SHALL treat a button still held when Reset_n deasserts mid-operation as a new press: full DB_CYC qualification, then one SCEN.

Configuration
REQ-024 SHALL, when macro SINDOKU_BTN_AUTOREPEAT_EN is defined, implement auto-repeat per REQ-015.
REQ-025 SHALL, when SINDOKU_BTN_AUTOREPEAT_EN is not defined, omit RPT_PULSE and RPT_WAIT: HOLD only waits for release, MCEN equals SCEN, and RPT_DLY and RPT_RATE are unused.

Verification (DB_CYC=4, RPT_DLY=10, RPT_RATE=5, macro defined; edge 0 is the first edge sampling PB=1)
REQ-026 SHALL verify that PB high for 3 cycles, then low, produces no SCEN, MCEN or DPB activity.
REQ-027 SHALL verify that PB held high from before edge 0 gives SCEN=MCEN=1 only in the cycle after edge 5 and DPB=1 from then on, with MCEN repeats in the cycles after edges 15, 20 and 25.
REQ-028 SHALL verify that PB going low before edge 40 gives no further MCEN and DPB falling after edge 45.
REQ-029 SHALL verify that a release bounce (PB low 2 cycles, then high again) during HOLD keeps DPB=1, produces no SCEN, and places the next MCEN exactly 10 cycles after the return to HOLD.
REQ-030 SHALL verify that Reset_n pulsed low during RPT_WAIT with PB held clears all outputs at once, and that after release a single SCEN follows 4 qualifying samples.
REQ-031 SHALL verify that with the macro undefined, PB held for 50 cycles yields exactly one MCEN, coincident with SCEN.
